aud_agc: RTL and testbench
==========================

# aud_agc

Automatic gain controller for the audio CIC decimator. It watches the decimated output samples, measures the peak magnitude over fixed windows, and steps the decimator's `gain` shift control down on loud or clipping signal and up on sustained quiet signal. After each change it holds off for a settling period. When disabled it passes a manual gain through.

## Interface
Parameters:
- `BITS`, 16: sample width; must match the decimator output width.
- `GAIN_BITS`, 8: width of `gain` and `manual_gain`.
- `GAIN_MAX`, 15: highest gain value the block ever drives.
- `GAIN_INIT`, 4: gain value after reset.
- `WINDOW`, 256: samples per measurement window.
- `HOLD`, 4: consecutive quiet windows required before a gain increase.
- `SETTLE`, 5: samples ignored after any gain change.
- `HI_THRESH`, 24576: window peak at or above this value decreases gain.
- `LO_THRESH`, 8192: window peak below this value counts as a quiet window.
- `CLIP_THRESH`, 32000: a single sample magnitude at or above this value is an immediate clip.

Ports:
- `CLK`, input, 1: clock.
- `RSTb`, input, 1: reset, synchronous, active-low.
- `in_tick`, input, 1: one-cycle sample strobe (the decimator's `out_tick`).
- `x_in`, input, BITS, signed: sample, valid while `in_tick` is high.
- `enable`, input, 1: 1 = AGC active, 0 = manual mode.
- `manual_gain`, input, GAIN_BITS: gain used in manual mode.
- `gain`, output, GAIN_BITS: drives the decimator `gain` input; registered.
- `gain_tick`, output, 1: one-cycle pulse in the first cycle an AGC-decided new `gain` value is presented.
- `clip`, output, 1: one-cycle pulse when a clip sample is detected.
- `peak_out`, output, BITS-1: peak of the last completed window, unsigned.

## Operation
- Magnitude: `mag = |x_in|`. The value -2^(BITS-1) saturates to 2^(BITS-1)-1, so `mag` fits in BITS-1 bits. All thresholds compare unsigned against `mag` or `peak`.
- States: IDLE, MEASURE, EVAL, HOLDOFF.
- Internal registers:
  - `cnt`: counts samples in MEASURE and in HOLDOFF.
  - `peak`: running maximum `mag` in the current window.
  - `low_cnt`: consecutive quiet windows, range 0..HOLD-1.
- Priority order: reset, then `enable`=0, then state logic.
- IDLE:
  - `gain` <= min(`manual_gain`, GAIN_MAX) every cycle.
  - `cnt`, `peak`, `low_cnt` are cleared.
  - When `enable`=1, go to MEASURE. The current `gain` is kept (bumpless).
- MEASURE, on each `in_tick`:
  - `peak` <= max(`peak`, `mag`) and `cnt` <= `cnt`+1.
  - If `mag` >= CLIP_THRESH: `clip` pulses; if `gain` > 0 then `gain` <= `gain`-1 and `gain_tick` pulses; `low_cnt` <= 0; go to HOLDOFF with `cnt`=0. The window is abandoned and `peak_out` is not updated. This check wins over window completion.
  - Otherwise, if `cnt` = WINDOW-1, go to EVAL. `peak` already includes this sample.
- EVAL, exactly one cycle:
  - `peak_out` <= `peak`.
  - If `peak` >= HI_THRESH: `low_cnt` <= 0; decrement `gain` if `gain` > 0.
  - Else if `peak` < LO_THRESH: if `low_cnt` = HOLD-1, set `low_cnt` <= 0 and increment `gain` if `gain` < GAIN_MAX; otherwise `low_cnt` <= `low_cnt`+1.
  - Else: `low_cnt` <= 0.
  - If `gain` changed: `gain_tick` pulses, go to HOLDOFF with `cnt`=0.
  - If `gain` did not change: go to MEASURE with `cnt`=0 and `peak`=0.
- HOLDOFF:
  - Samples are ignored for magnitude and clip.
  - `cnt` counts `in_tick`s; on the SETTLE-th tick, go to MEASURE with `cnt`=0 and `peak`=0.
- Gain changes only by ±1 per decision and is never driven outside [0, GAIN_MAX].
- An `in_tick` arriving in the EVAL cycle is dropped. In-system the tick spacing is hundreds of cycles, so this does not occur.

## Timing
- Reset values: `gain`=GAIN_INIT, `gain_tick`=0, `clip`=0, `peak_out`=0, state IDLE, all counters 0.
- Let T be the cycle in which the final window `in_tick` is high:
  - State is EVAL in T+1.
  - New `gain`, `gain_tick`, and new `peak_out` are all visible in T+2.
- Clip on the `in_tick` in cycle T: `clip`, `gain_tick`, and new `gain` are visible in T+1.
- `enable` falling in cycle T: state is IDLE and `gain` = clamped `manual_gain` in T+1. No `gain_tick` is generated.
- `enable` rising in cycle T: state is MEASURE in T+1, and counting starts with the next `in_tick`.
- Reset mid-operation: all state returns to the reset values on the next edge. Any in-flight window is discarded.

## Test plan
- Quiet signal: reset, `enable`=1, `x_in`=1000 constant for 1024 ticks -> single `gain_tick` with `gain` 4->5 in T+2 after tick 1024. `peak_out`=1000 after each window.
- Loud signal: `x_in`=30000 constant -> `gain` 4->3 after tick 256, then a 5-tick holdoff, then 3->2 after a further 256 ticks. `clip` stays 0.
- Clip with saturation: one sample of -32768 at tick 100 -> `clip` and `gain_tick` in T+1, `gain`=3. The following 5 ticks are ignored, `low_cnt` is cleared, and `peak_out` is unchanged.
- Floor: `manual_gain`=0, then `enable`=1, `x_in`=30000 -> no `gain_tick` and `gain` stays 0. The next window starts immediately (no holdoff), and `peak_out`=30000.
- Ceiling and clamp: `enable`=0, `manual_gain`=20 -> `gain`=15. Then `enable`=1 with `x_in`=0 for 2048 ticks -> `gain` stays 15 and no `gain_tick`.
- Disable mid-window: drop `enable` at tick 128 with `manual_gain`=7 -> `gain`=7 next cycle. Re-enable -> the full 256-tick window restarts from `cnt`=0.

Source files
------------

// File: rtl/aud_agc.sv
// Automatic gain controller for the CIC decimator: measures windowed peak
// magnitude and steps the decimator gain shift down on loud/clipping input, up on sustained quiet.
module aud_agc #(
  parameter int BITS        = 16,
  parameter int GAIN_BITS   = 8,
  parameter int GAIN_MAX    = 15,
  parameter int GAIN_INIT   = 4,
  parameter int WINDOW      = 256,
  parameter int HOLD        = 4,
  parameter int SETTLE      = 5,
  parameter int HI_THRESH   = 24576,
  parameter int LO_THRESH   = 8192,
  parameter int CLIP_THRESH = 32000
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic                   in_tick,
  input  logic signed [BITS-1:0] x_in,
  input  logic                   enable,
  input  logic [GAIN_BITS-1:0]   manual_gain,
  output logic [GAIN_BITS-1:0]   gain,
  output logic                   gain_tick,
  output logic                   clip,
  output logic [BITS-2:0]        peak_out
);

  localparam int CNT_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOW_W   = $clog2(HOLD + 1);

  localparam logic [GAIN_BITS-1:0] G_MAX  = GAIN_BITS'(GAIN_MAX);
  localparam logic [GAIN_BITS-1:0] G_ONE  = GAIN_BITS'(1);
  localparam logic [BITS-2:0]      HI_T   = (BITS-1)'(HI_THRESH);
  localparam logic [BITS-2:0]      LO_T   = (BITS-1)'(LO_THRESH);
  localparam logic [BITS-2:0]      CLIP_T = (BITS-1)'(CLIP_THRESH);
  localparam logic [CNT_W-1:0]     WIN_LAST    = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [LOW_W-1:0]     LOW_LAST    = LOW_W'(HOLD - 1);
  localparam logic [LOW_W-1:0]     LOW_ONE     = LOW_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_EVAL, S_HOLDOFF} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BITS-2:0]      peak, peak_nxt;
  logic [LOW_W-1:0]     low_cnt, low_nxt;
  logic [GAIN_BITS-1:0] gain_nxt;
  logic                 gain_tick_nxt, clip_nxt;
  logic [BITS-2:0]      peak_out_nxt;

  logic [BITS-1:0]      x_neg;
  logic [BITS-2:0]      mag;
  logic [GAIN_BITS-1:0] manual_clamped;

  // The most negative sample negates to itself; saturate it to full scale.
  assign x_neg = BITS'(-x_in);
  assign mag   = !x_in[BITS-1] ? x_in[BITS-2:0]
               : (x_neg[BITS-1] ? '1 : x_neg[BITS-2:0]);

  assign manual_clamped = (manual_gain > G_MAX) ? G_MAX : manual_gain;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state     <= S_IDLE;
      cnt       <= '0;
      peak      <= '0;
      low_cnt   <= '0;
      gain      <= GAIN_BITS'(GAIN_INIT);
      gain_tick <= 1'b0;
      clip      <= 1'b0;
      peak_out  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      peak      <= peak_nxt;
      low_cnt   <= low_nxt;
      gain      <= gain_nxt;
      gain_tick <= gain_tick_nxt;
      clip      <= clip_nxt;
      peak_out  <= peak_out_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    peak_nxt      = peak;
    low_nxt       = low_cnt;
    gain_nxt      = gain;
    gain_tick_nxt = 1'b0;
    clip_nxt      = 1'b0;
    peak_out_nxt  = peak_out;

    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      peak_nxt  = '0;
      low_nxt   = '0;
      gain_nxt  = manual_clamped;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Bumpless entry: the manual gain already in place is kept.
          cnt_nxt   = '0;
          peak_nxt  = '0;
          low_nxt   = '0;
          state_nxt = S_MEASURE;
        end

        S_MEASURE: begin
          if (in_tick) begin
            if (mag >= CLIP_T) begin
              clip_nxt = 1'b1;
              if (gain != '0) begin
                gain_nxt      = gain - G_ONE;
                gain_tick_nxt = 1'b1;
              end
              low_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = S_HOLDOFF;
            end else begin
              peak_nxt = (mag > peak) ? mag : peak;
              cnt_nxt  = cnt + CNT_ONE;
              if (cnt == WIN_LAST) state_nxt = S_EVAL;
            end
          end
        end

        S_EVAL: begin
          peak_out_nxt = peak;
          if (peak >= HI_T) begin
            low_nxt = '0;
            if (gain != '0) begin
              gain_nxt      = gain - G_ONE;
              gain_tick_nxt = 1'b1;
            end
          end else if (peak < LO_T) begin
            if (low_cnt == LOW_LAST) begin
              low_nxt = '0;
              if (gain < G_MAX) begin
                gain_nxt      = gain + G_ONE;
                gain_tick_nxt = 1'b1;
              end
            end else begin
              low_nxt = low_cnt + LOW_ONE;
            end
          end else begin
            low_nxt = '0;
          end
          cnt_nxt = '0;
          if (gain_tick_nxt) begin
            state_nxt = S_HOLDOFF;
          end else begin
            peak_nxt  = '0;
            state_nxt = S_MEASURE;
          end
        end

        S_HOLDOFF: begin
          if (in_tick) begin
            if (cnt == SETTLE_LAST) begin
              cnt_nxt   = '0;
              peak_nxt  = '0;
              state_nxt = S_MEASURE;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_agc.sv
// Self-checking bench for aud_agc: directed scenarios plus randomized samples
// checked against a sample-level window/holdoff model.
module tb_aud_agc;

  localparam int BITS        = 16;
  localparam int GAIN_BITS   = 8;
  localparam int GAIN_MAX    = 15;
  localparam int GAIN_INIT   = 4;
  localparam int WINDOW      = 256;
  localparam int HOLD        = 4;
  localparam int SETTLE      = 5;
  localparam int HI_THRESH   = 24576;
  localparam int LO_THRESH   = 8192;
  localparam int CLIP_THRESH = 32000;

  logic                   CLK = 1'b0;
  logic                   RSTb = 1'b0;
  logic                   in_tick = 1'b0;
  logic signed [BITS-1:0] x_in = '0;
  logic                   enable = 1'b0;
  logic [GAIN_BITS-1:0]   manual_gain = '0;
  logic [GAIN_BITS-1:0]   gain;
  logic                   gain_tick;
  logic                   clip;
  logic [BITS-2:0]        peak_out;

  always #5 CLK = ~CLK;

  aud_agc #(
    .BITS(BITS), .GAIN_BITS(GAIN_BITS), .GAIN_MAX(GAIN_MAX), .GAIN_INIT(GAIN_INIT),
    .WINDOW(WINDOW), .HOLD(HOLD), .SETTLE(SETTLE), .HI_THRESH(HI_THRESH),
    .LO_THRESH(LO_THRESH), .CLIP_THRESH(CLIP_THRESH)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x_in(x_in), .enable(enable),
    .manual_gain(manual_gain), .gain(gain), .gain_tick(gain_tick), .clip(clip),
    .peak_out(peak_out)
  );

  int errors = 0;
  int checks = 0;
  int n_tick = 0;

  // Reference model: expected gain/peak from the window contents and settle count.
  int m_gain, m_peak_out, m_low, m_settle, m_manual;
  bit m_en;
  int win[$];

  function automatic int clamp_gain(input int v);
    return (v > GAIN_MAX) ? GAIN_MAX : v;
  endfunction

  function automatic int mag_of(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  task automatic model_tick(input int x, output bit clip_e, output bit gt1, output bit gt2);
    int m, pk, old;
    clip_e = 0; gt1 = 0; gt2 = 0;
    if (!m_en) return;
    if (m_settle > 0) begin
      m_settle--;
      return;
    end
    m = mag_of(x);
    if (m >= CLIP_THRESH) begin
      clip_e = 1;
      if (m_gain > 0) begin m_gain--; gt1 = 1; end
      m_low = 0;
      win.delete();
      m_settle = SETTLE;
      return;
    end
    win.push_back(m);
    if (win.size() == WINDOW) begin
      pk = 0;
      foreach (win[i]) if (win[i] > pk) pk = win[i];
      win.delete();
      m_peak_out = pk;
      old = m_gain;
      if (pk >= HI_THRESH) begin
        m_low = 0;
        if (m_gain > 0) m_gain--;
      end else if (pk < LO_THRESH) begin
        if (m_low == HOLD - 1) begin
          m_low = 0;
          if (m_gain < GAIN_MAX) m_gain++;
        end else begin
          m_low++;
        end
      end else begin
        m_low = 0;
      end
      if (m_gain != old) begin
        gt2 = 1;
        m_settle = SETTLE;
      end
    end
  endtask

  // Drive one sample in cycle T; check clip/gain_tick in T+1, gain/peak_out in T+2.
  task automatic send(input int x);
    bit c, g1, g2;
    model_tick(x, c, g1, g2);
    n_tick++;
    x_in = 16'(x);
    in_tick = 1'b1;
    @(posedge CLK); @(negedge CLK);
    in_tick = 1'b0;
    checks++;
    if (clip !== c) begin
      errors++;
      $display("FAIL clip_t1 tick=%0d x=%0d: got %0b expected %0b", n_tick, x, clip, c);
    end
    checks++;
    if (gain_tick !== g1) begin
      errors++;
      $display("FAIL gain_tick_t1 tick=%0d x=%0d: got %0b expected %0b", n_tick, x, gain_tick, g1);
    end
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (gain_tick !== g2) begin
      errors++;
      $display("FAIL gain_tick_t2 tick=%0d x=%0d: got %0b expected %0b", n_tick, x, gain_tick, g2);
    end
    checks++;
    if (clip !== 1'b0) begin
      errors++;
      $display("FAIL clip_t2 tick=%0d: got %0b expected 0", n_tick, clip);
    end
    checks++;
    if (gain !== GAIN_BITS'(m_gain)) begin
      errors++;
      $display("FAIL gain tick=%0d: got %0d expected %0d", n_tick, gain, m_gain);
    end
    checks++;
    if (peak_out !== 15'(m_peak_out)) begin
      errors++;
      $display("FAIL peak_out tick=%0d: got %0d expected %0d", n_tick, peak_out, m_peak_out);
    end
  endtask

  task automatic set_enable(input bit en, input int man);
    enable = en;
    manual_gain = GAIN_BITS'(man);
    m_manual = man;
    if (!en) begin
      m_gain = clamp_gain(man);
      win.delete();
      m_low = 0;
      m_settle = 0;
    end
    m_en = en;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (gain !== GAIN_BITS'(m_gain)) begin
      errors++;
      $display("FAIL enable_gain en=%0b man=%0d: got %0d expected %0d", en, man, gain, m_gain);
    end
    checks++;
    if (gain_tick !== 1'b0) begin
      errors++;
      $display("FAIL enable_gain_tick en=%0b: got %0b expected 0", en, gain_tick);
    end
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({gain, gain_tick, clip, peak_out} !== {GAIN_BITS'(GAIN_INIT), 1'b0, 1'b0, 15'd0}) begin
      errors++;
      $display("FAIL reset_values: got gain=%0d gt=%0b clip=%0b peak=%0d expected gain=%0d gt=0 clip=0 peak=0",
               gain, gain_tick, clip, peak_out, GAIN_INIT);
    end
    @(posedge CLK); @(negedge CLK);
    RSTb = 1'b1;
    m_gain = GAIN_INIT;
    m_peak_out = 0;
    m_low = 0;
    m_settle = 0;
    win.delete();
    if (!m_en) m_gain = clamp_gain(m_manual);
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (gain !== GAIN_BITS'(m_gain)) begin
      errors++;
      $display("FAIL post_reset_gain: got %0d expected %0d", gain, m_gain);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0; m_en = 0;
    manual_gain = 8'd9; m_manual = 9;
    do_reset();
  endtask

  task automatic test_quiet();
    enable = 1'b1; m_en = 1;
    do_reset();
    for (int i = 0; i < 4 * WINDOW; i++) send(1000);
    checks++;
    if (gain !== 8'd5 || peak_out !== 15'd1000) begin
      errors++;
      $display("FAIL quiet_final: got gain=%0d peak=%0d expected gain=5 peak=1000", gain, peak_out);
    end
  endtask

  task automatic test_loud();
    do_reset();
    for (int i = 0; i < 2 * WINDOW + SETTLE; i++) send(30000);
    checks++;
    if (gain !== 8'd2) begin
      errors++;
      $display("FAIL loud_final: got gain=%0d expected 2", gain);
    end
  endtask

  task automatic test_clip();
    do_reset();
    for (int i = 0; i < 3 * WINDOW; i++) send(int'($urandom_range(0, 5000)) - 2500);
    for (int i = 0; i < 99; i++) send(1000);
    send(-32768);
    checks++;
    if (gain !== 8'd3 || peak_out !== 15'(m_peak_out)) begin
      errors++;
      $display("FAIL clip_final: got gain=%0d peak=%0d expected gain=3 peak=%0d", gain, peak_out, m_peak_out);
    end
    for (int i = 0; i < SETTLE; i++) send(-32768);
    for (int i = 0; i < 4 * WINDOW; i++) send(1000);
  endtask

  task automatic test_floor();
    set_enable(0, 0);
    set_enable(1, 0);
    for (int i = 0; i < 2 * WINDOW; i++) send(30000);
    checks++;
    if (gain !== 8'd0 || peak_out !== 15'd30000) begin
      errors++;
      $display("FAIL floor_final: got gain=%0d peak=%0d expected gain=0 peak=30000", gain, peak_out);
    end
  endtask

  task automatic test_ceiling();
    set_enable(0, 20);
    set_enable(1, 20);
    for (int i = 0; i < 8 * WINDOW; i++) send(0);
  endtask

  task automatic test_disable_mid();
    enable = 1'b1; m_en = 1;
    do_reset();
    for (int i = 0; i < WINDOW / 2; i++) send(20000);
    set_enable(0, 7);
    set_enable(1, 7);
    for (int i = 0; i < WINDOW; i++) send(30000);
    checks++;
    if (gain !== 8'd6) begin
      errors++;
      $display("FAIL disable_mid_final: got gain=%0d expected 6", gain);
    end
  endtask

  task automatic test_random();
    int regime, r, m, x, act;
    for (int seg = 0; seg < 10; seg++) begin
      regime = int'($urandom_range(0, 2));
      for (int i = 0; i < 300; i++) begin
        r = int'($urandom_range(0, 999));
        if (r < 2) x = -32768;
        else if (r < 4) x = 32000 + int'($urandom_range(0, 767));
        else begin
          case (regime)
            0:       m = int'($urandom_range(0, LO_THRESH - 1));
            1:       m = int'($urandom_range(LO_THRESH, HI_THRESH - 1));
            default: m = int'($urandom_range(HI_THRESH, CLIP_THRESH - 1));
          endcase
          x = $urandom_range(0, 1) ? -m : m;
        end
        send(x);
      end
      act = int'($urandom_range(0, 9));
      if (act < 3) begin
        set_enable(0, int'($urandom_range(0, 31)));
        if (act < 2) send(12345);
        set_enable(1, m_manual);
      end else if (act == 3) begin
        do_reset();
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_en = 0; m_manual = 0; m_gain = GAIN_INIT; m_peak_out = 0; m_low = 0; m_settle = 0;
    @(negedge CLK);
    test_reset();
    test_quiet();
    test_loud();
    test_clip();
    test_floor();
    test_ceiling();
    test_disable_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
